// File: rtl/id_pipe.sv
// RV32I decode stage: decodes the IF/ID beat, resolves operands with EX/MEM
// forwarding and a load-use interlock, and holds the result in a one-entry output register.

module id_src #(
   parameter bit FWD_EN = 1'b1
) (
   input  logic        re,
   input  logic [4:0]  addr,
   input  logic [31:0] rdata,
   input  logic        ex_we,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_waddr,
   input  logic [31:0] ex_wdata,
   input  logic        mem_we,
   input  logic [4:0]  mem_waddr,
   input  logic [31:0] mem_wdata,
   input  logic        oreg_ld,
   input  logic [4:0]  oreg_waddr,
   output logic [31:0] val,
   output logic        haz
);
   logic nz, ex_hit, mem_hit;

   assign nz      = (addr != 5'd0);
   assign ex_hit  = ex_we && (ex_waddr == addr);
   assign mem_hit = mem_we && (mem_waddr == addr);

   // A load result is not available until MEM, so EX loads never forward.
   always_comb begin
      val = rdata;
      if (!nz)                                    val = 32'd0;
      else if (FWD_EN && ex_hit && !ex_is_load)   val = ex_wdata;
      else if (FWD_EN && mem_hit)                 val = mem_wdata;
   end

   assign haz = re && nz &&
                ((oreg_ld && (oreg_waddr == addr)) ||
                 (ex_hit && ex_is_load) ||
                 (!FWD_EN && (ex_hit || mem_hit)));
endmodule

module id_pipe #(
   parameter bit FWD_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_inst,
   output logic [4:0]       raddr1,
   output logic [4:0]       raddr2,
   output logic             re1,
   output logic             re2,
   input  logic [31:0]      rdata1,
   input  logic [31:0]      rdata2,
   input  logic             ex_we,
   input  logic             ex_is_load,
   input  logic [4:0]       ex_waddr,
   input  logic [31:0]      ex_wdata,
   input  logic             mem_we,
   input  logic [4:0]       mem_waddr,
   input  logic [31:0]      mem_wdata,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [6:0]       out_opcode,
   output logic [2:0]       out_funct3,
   output logic             out_alt,
   output logic [31:0]      out_op1,
   output logic [31:0]      out_op2,
   output logic [31:0]      out_imm,
   output logic             out_we,
   output logic [4:0]       out_waddr,
   output logic             out_illegal,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_OP    = 7'b0110011;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        alt;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] imm;
      logic        we;
      logic [4:0]  waddr;
      logic        illegal;
   } dec_t;

   dec_t        dec, oreg;
   logic        vld;
   logic        use1, use2, d_we, d_alt, d_ill;
   logic [31:0] d_imm;
   logic        f7_zero, f7_alt;
   logic        stall, capture, oreg_ld;

   logic [6:0] opc;
   logic [2:0] f3;
   assign opc     = in_inst[6:0];
   assign f3      = in_inst[14:12];
   assign f7_zero = (in_inst[31:25] == 7'b0000000);
   assign f7_alt  = (in_inst[31:25] == 7'b0100000);

   always_comb begin
      use1  = 1'b0;
      use2  = 1'b0;
      d_we  = 1'b0;
      d_alt = 1'b0;
      d_ill = 1'b0;
      d_imm = 32'd0;
      case (opc)
         OP_LUI, OP_AUIPC: begin
            d_we  = 1'b1;
            d_imm = {in_inst[31:12], 12'b0};
         end
         OP_JAL: begin
            d_we  = 1'b1;
            d_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
         end
         OP_JALR: begin
            d_we  = 1'b1;
            use1  = 1'b1;
            d_imm = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         OP_LD: begin
            d_we  = 1'b1;
            use1  = 1'b1;
            d_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            d_ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OP_ST: begin
            use1  = 1'b1;
            use2  = 1'b1;
            d_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            d_ill = (f3 > 3'b010);
         end
         OP_BR: begin
            use1  = 1'b1;
            use2  = 1'b1;
            d_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            d_ill = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OP_IMM: begin
            d_we = 1'b1;
            use1 = 1'b1;
            if (f3 == 3'b001) begin
               d_imm = {27'b0, in_inst[24:20]};
               d_ill = !f7_zero;
            end else if (f3 == 3'b101) begin
               d_imm = {27'b0, in_inst[24:20]};
               d_alt = in_inst[30];
               d_ill = !(f7_zero || f7_alt);
            end else begin
               d_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            end
         end
         OP_OP: begin
            d_we  = 1'b1;
            use1  = 1'b1;
            use2  = 1'b1;
            d_alt = in_inst[30];
            d_ill = !(f7_zero || (f7_alt && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         default: d_ill = 1'b1;
      endcase
   end

   assign raddr1 = in_inst[19:15];
   assign raddr2 = in_inst[24:20];
   assign re1    = in_valid & use1;
   assign re2    = in_valid & use2;

   assign oreg_ld = vld && oreg.we && (oreg.opcode == OP_LD);

   logic [1:0]       src_re, src_haz;
   logic [1:0][4:0]  src_addr;
   logic [1:0][31:0] src_rdata, src_val;

   assign src_re    = {re2, re1};
   assign src_addr  = {raddr2, raddr1};
   assign src_rdata = {rdata2, rdata1};

   for (genvar s = 0; s < 2; s++) begin : g_src
      id_src #(.FWD_EN(FWD_EN)) u_src (
         .re         (src_re[s]),
         .addr       (src_addr[s]),
         .rdata      (src_rdata[s]),
         .ex_we      (ex_we),
         .ex_is_load (ex_is_load),
         .ex_waddr   (ex_waddr),
         .ex_wdata   (ex_wdata),
         .mem_we     (mem_we),
         .mem_waddr  (mem_waddr),
         .mem_wdata  (mem_wdata),
         .oreg_ld    (oreg_ld),
         .oreg_waddr (oreg.waddr),
         .val        (src_val[s]),
         .haz        (src_haz[s])
      );
   end

   assign stall    = in_valid & (|src_haz);
   assign in_ready = flush | (!stall & (!vld | out_ready));
   assign capture  = in_valid & in_ready & !flush;

   always_comb begin
      dec.pc      = in_pc;
      dec.opcode  = opc;
      dec.funct3  = f3;
      dec.alt     = d_alt;
      dec.op1     = src_val[0];
      dec.op2     = src_val[1];
      dec.imm     = d_ill ? 32'd0 : d_imm;
      dec.we      = d_we & !d_ill;
      dec.waddr   = in_inst[11:7];
      dec.illegal = d_ill;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld       <= 1'b0;
         oreg      <= '0;
         stall_cnt <= '0;
      end else begin
         if (flush)          vld <= 1'b0;
         else if (capture) begin
            vld  <= 1'b1;
            oreg <= dec;
         end else if (out_ready) vld <= 1'b0;
         if (stall && !flush && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign out_valid   = vld;
   assign out_pc      = oreg.pc;
   assign out_opcode  = oreg.opcode;
   assign out_funct3  = oreg.funct3;
   assign out_alt     = oreg.alt;
   assign out_op1     = oreg.op1;
   assign out_op2     = oreg.op2;
   assign out_imm     = oreg.imm;
   assign out_we      = oreg.we;
   assign out_waddr   = oreg.waddr;
   assign out_illegal = oreg.illegal;
endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: forwarding instance plus a no-forward, 2-bit counter instance.

module tb_id_pipe;
   logic        clk = 1'b0;
   logic        rst, b_rst;
   logic        in_valid, flush, out_ready;
   logic [31:0] in_pc, in_inst;
   logic [31:0] rdata1, rdata2;
   logic        ex_we, ex_is_load, mem_we;
   logic [4:0]  ex_waddr, mem_waddr;
   logic [31:0] ex_wdata, mem_wdata;

   logic        in_ready, re1, re2, out_valid, out_alt, out_we, out_illegal;
   logic [4:0]  raddr1, raddr2, out_waddr;
   logic [31:0] out_pc, out_op1, out_op2, out_imm;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic [15:0] stall_cnt;

   logic        b_in_ready, b_re1, b_re2, b_out_valid, b_out_alt, b_out_we, b_out_illegal;
   logic [4:0]  b_raddr1, b_raddr2, b_out_waddr;
   logic [31:0] b_out_pc, b_out_op1, b_out_op2, b_out_imm;
   logic [6:0]  b_out_opcode;
   logic [2:0]  b_out_funct3;
   logic [1:0]  b_stall_cnt;

   always #5 clk = ~clk;

   // regfile model: each register reads back a tagged copy of its index
   assign rdata1 = 32'hA000_0000 | {27'd0, raddr1};
   assign rdata2 = 32'hB000_0000 | {27'd0, raddr2};

   id_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .raddr1(raddr1), .raddr2(raddr2), .re1(re1), .re2(re2), .rdata1(rdata1), .rdata2(rdata2),
      .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
      .out_funct3(out_funct3), .out_alt(out_alt), .out_op1(out_op1), .out_op2(out_op2),
      .out_imm(out_imm), .out_we(out_we), .out_waddr(out_waddr), .out_illegal(out_illegal),
      .stall_cnt(stall_cnt)
   );

   id_pipe #(.FWD_EN(1'b0), .CNT_W(2)) dut_b (
      .clk(clk), .rst(b_rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .raddr1(b_raddr1), .raddr2(b_raddr2), .re1(b_re1), .re2(b_re2), .rdata1(rdata1), .rdata2(rdata2),
      .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .flush(flush),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_opcode(b_out_opcode),
      .out_funct3(b_out_funct3), .out_alt(b_out_alt), .out_op1(b_out_op1), .out_op2(b_out_op2),
      .out_imm(b_out_imm), .out_we(b_out_we), .out_waddr(b_out_waddr), .out_illegal(b_out_illegal),
      .stall_cnt(b_stall_cnt)
   );

   typedef struct {
      logic [31:0] pc;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        alt;
      logic [31:0] op1;
      logic        c1;
      logic [31:0] op2;
      logic        c2;
      logic [31:0] imm;
      logic        we;
      logic [4:0]  wa;
      logic        ill;
   } exp_t;

   exp_t sbq[$];
   int   n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, act, exp);
   endtask

   function automatic exp_t mk(input logic [31:0] pc, input logic [6:0] opc, input logic [2:0] f3,
                               input logic alt, input logic [31:0] op1, input logic c1,
                               input logic [31:0] op2, input logic c2, input logic [31:0] imm,
                               input logic we, input logic [4:0] wa, input logic ill);
      exp_t e;
      e.pc = pc; e.opc = opc; e.f3 = f3; e.alt = alt; e.op1 = op1; e.c1 = c1;
      e.op2 = op2; e.c2 = c2; e.imm = imm; e.we = we; e.wa = wa; e.ill = ill;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sbq.size() == 0) chk("unexpected_out", out_pc, 32'hFFFF_FFFF);
         else begin
            exp_t e;
            e = sbq.pop_front();
            chk("pc", out_pc, e.pc);
            chk("opcode", 32'(out_opcode), 32'(e.opc));
            chk("funct3", 32'(out_funct3), 32'(e.f3));
            chk("alt", 32'(out_alt), 32'(e.alt));
            chk("imm", out_imm, e.imm);
            chk("we", 32'(out_we), 32'(e.we));
            chk("illegal", 32'(out_illegal), 32'(e.ill));
            if (e.we) chk("waddr", 32'(out_waddr), 32'(e.wa));
            if (e.c1) chk("op1", out_op1, e.op1);
            if (e.c2) chk("op2", out_op2, e.op2);
         end
      end
   end

   task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input exp_t e);
      int n = 0;
      in_valid = 1'b1; in_pc = pc; in_inst = inst;
      @(negedge clk);
      while (!in_ready && n < 20) begin n++; @(negedge clk); end
      if (in_ready) sbq.push_back(e);
      else chk("offer_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   logic [31:0] tbl_inst[9];
   exp_t        tbl_exp[9];

   initial begin
      rst = 1'b1; b_rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_pc = '0; in_inst = '0; ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = '0; ex_wdata = '0;
      mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_we", 32'(out_we), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_re1_idle", 32'(re1), 32'd0);
      @(posedge clk); #1;

      // back-to-back decode of assorted formats, legal and illegal
      tbl_inst[0] = 32'h0050_0093; tbl_exp[0] = mk(32'h100, 7'h13, 3'd0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd5, 1'b1, 5'd1, 1'b0);
      tbl_inst[1] = 32'h4020_83B3; tbl_exp[1] = mk(32'h104, 7'h33, 3'd0, 1'b1, 32'hA000_0001, 1'b1, 32'hB000_0002, 1'b1, 32'd0, 1'b1, 5'd7, 1'b0);
      tbl_inst[2] = 32'h4032_5213; tbl_exp[2] = mk(32'h108, 7'h13, 3'd5, 1'b1, 32'hA000_0004, 1'b1, 32'd0, 1'b0, 32'd3, 1'b1, 5'd4, 1'b0);
      tbl_inst[3] = 32'h4032_1213; tbl_exp[3] = mk(32'h10C, 7'h13, 3'd1, 1'b0, 32'hA000_0004, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      tbl_inst[4] = 32'h0020_A423; tbl_exp[4] = mk(32'h110, 7'h23, 3'd2, 1'b0, 32'hA000_0001, 1'b1, 32'hB000_0002, 1'b1, 32'd8, 1'b0, 5'd0, 1'b0);
      tbl_inst[5] = 32'hFE00_0EE3; tbl_exp[5] = mk(32'h114, 7'h63, 3'd0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 1'b0);
      tbl_inst[6] = 32'hFFFF_FFFF; tbl_exp[6] = mk(32'h118, 7'h7F, 3'd7, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      tbl_inst[7] = 32'h0000_2063; tbl_exp[7] = mk(32'h11C, 7'h63, 3'd2, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, 32'd0, 1'b0, 5'd0, 1'b1);
      tbl_inst[8] = 32'h1234_5437; tbl_exp[8] = mk(32'h120, 7'h37, 3'd5, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h1234_5000, 1'b1, 5'd8, 1'b0);
      for (int i = 0; i < 9; i++) offer(tbl_exp[i].pc, tbl_inst[i], tbl_exp[i]);

      // EX beats MEM; then MEM alone
      ex_we = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'hDEAD;
      mem_we = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'h1111;
      offer(32'h200, 32'h0021_01B3, mk(32'h200, 7'h33, 3'd0, 1'b0, 32'hDEAD, 1'b1, 32'hDEAD, 1'b1, 32'd0, 1'b1, 5'd3, 1'b0));
      ex_we = 1'b0;
      offer(32'h204, 32'h0021_01B3, mk(32'h204, 7'h33, 3'd0, 1'b0, 32'h1111, 1'b1, 32'h1111, 1'b1, 32'd0, 1'b1, 5'd3, 1'b0));
      mem_we = 1'b0;
      chk("fwd_stall_cnt", 32'(stall_cnt), 32'd0);

      // load-use: one bubble, then MEM forward of load data
      offer(32'h300, 32'h0000_A283, mk(32'h300, 7'h03, 3'd2, 1'b0, 32'hA000_0001, 1'b1, 32'd0, 1'b0, 32'd0, 1'b1, 5'd5, 1'b0));
      in_valid = 1'b1; in_pc = 32'h304; in_inst = 32'h0052_8333;
      @(negedge clk);
      chk("lu_in_ready_stall", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      mem_we = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'h5A5A_0005;
      @(negedge clk);
      chk("lu_in_ready_go", 32'(in_ready), 32'd1);
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      if (in_ready) sbq.push_back(mk(32'h304, 7'h33, 3'd0, 1'b0, 32'h5A5A_0005, 1'b1, 32'h5A5A_0005, 1'b1, 32'd0, 1'b1, 5'd6, 1'b0));
      @(posedge clk); #1;
      in_valid = 1'b0; mem_we = 1'b0;

      // EX load against a source stalls even with forwarding
      ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd2;
      in_valid = 1'b1; in_pc = 32'h308; in_inst = 32'h0021_01B3;
      @(negedge clk);
      chk("exld_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("exld_stall_cnt", 32'(stall_cnt), 32'd2);
      in_valid = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0;
      @(posedge clk); #1;

      // backpressure: hold three cycles, then capture on the draining edge
      offer(32'h400, 32'h0050_0093, mk(32'h400, 7'h13, 3'd0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd5, 1'b1, 5'd1, 1'b0));
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h404; in_inst = 32'h1234_5437;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_pc", out_pc, 32'h400);
         chk("bp_out_imm", out_imm, 32'd5);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_release", 32'(in_ready), 32'd1);
      if (in_ready) sbq.push_back(mk(32'h404, 7'h37, 3'd5, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h1234_5000, 1'b1, 5'd8, 1'b0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_stall_cnt", 32'(stall_cnt), 32'd2);
      @(posedge clk); #1;

      // flush kills the held entry and the offered beat
      offer(32'h500, 32'h0010_0493, mk(32'h500, 7'h13, 3'd0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd1, 1'b1, 5'd9, 1'b0));
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h504; in_inst = 32'h1234_5437; flush = 1'b1;
      @(negedge clk);
      chk("fl_in_ready", 32'(in_ready), 32'd1);
      chk("fl_out_valid_held", 32'(out_valid), 32'd1);
      sbq.delete();
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("fl_out_valid_cleared", 32'(out_valid), 32'd0);
      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      // no-forward instance: held EX RAW stalls, 2-bit counter saturates
      @(posedge clk); #1;
      rst = 1'b1; b_rst = 1'b0;
      ex_we = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'hDEAD;
      in_valid = 1'b1; in_pc = 32'h600; in_inst = 32'h0021_01B3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("nf_in_ready", 32'(b_in_ready), 32'd0);
         chk("nf_stall_cnt", 32'(b_stall_cnt), (i < 3) ? i : 3);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("nf_stall_cnt_sat", 32'(b_stall_cnt), 32'd3);
      chk("nf_re1", 32'(b_re1), 32'd1);
      chk("nf_raddr1", 32'(b_raddr1), 32'd2);
      ex_we = 1'b0;
      #1;
      chk("nf_in_ready_clear", 32'(b_in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("nf_out_valid", 32'(b_out_valid), 32'd1);
      chk("nf_out_op1", b_out_op1, 32'hA000_0002);
      chk("nf_stall_cnt_hold", 32'(b_stall_cnt), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule

// File: doc/id_pipe.md
# id_pipe

Registered RV32I decode stage with valid/ready handshakes, operand forwarding, a load-use interlock, flush, and a stall counter. It sits between the IF/ID buffer and the EX stage. It decodes the incoming instruction, reads and forwards its source operands, and captures the result in a one-entry output register. EX consumes that register through a valid/ready handshake.

## Interface
- FWD_EN, 1: 1 = forward EX/MEM results to operands; 0 = stall on any RAW hazard against EX/MEM instead of forwarding.
- CNT_W, 16: width of the saturating stall counter.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  IF/ID offers an instruction.
- in_ready  out  1  stage accepts the offered beat this cycle.
- in_pc  in  32  instruction address.
- in_inst  in  32  instruction word.
- raddr1 / raddr2  out  5  regfile read addresses: inst[19:15] and inst[24:20]. Combinational from in_inst.
- re1 / re2  out  1  regfile read enables. Driven by format; 0 when in_valid=0.
- rdata1 / rdata2  in  32  regfile read data, same cycle.
- ex_we, ex_is_load  in  1  EX-stage instruction writes rd; EX-stage instruction is a load.
- ex_waddr  in  5  EX-stage rd.
- ex_wdata  in  32  EX-stage result.
- mem_we  in  1  MEM-stage write enable.
- mem_waddr  in  5  MEM-stage rd.
- mem_wdata  in  32  MEM-stage result.
- flush  in  1  branch/jump redirect; kill contents.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  EX accepts it.
- out_pc  out  32  instruction address.
- out_opcode  out  7  instruction opcode.
- out_funct3  out  3  instruction funct3.
- out_alt  out  1  funct7[5] for R-type, SRAI, SUB/SRA; else 0.
- out_op1 / out_op2  out  32  resolved rs1/rs2 values.
- out_imm  out  32  sign-extended immediate.
- out_we  out  1  instruction writes rd.
- out_waddr  out  5  rd.
- out_illegal  out  1  instruction is illegal.
- stall_cnt  out  CNT_W  number of interlock stall cycles.

## Operation
- Formats:
  - LUI/AUIPC: U-type, imm {inst[31:12],12'b0}, re1=re2=0.
  - JAL: J-type, re1=re2=0.
  - JALR, loads, OP-IMM: I-type, re1=1.
  - Stores: S-type, re1=re2=1, we=0.
  - Branches: B-type, re1=re2=1, we=0.
  - OP: imm 0, re1=re2=1.
  - Shift-immediates: imm = {27'b0, shamt}.
- Illegal cases:
  - unknown opcode;
  - branch funct3 010/011;
  - load funct3 011/11x;
  - store funct3 >010;
  - funct7 other than 0000000, or 0100000 where permitted (SUB, SRA, SRAI).
- An illegal instruction gives out_illegal=1, out_we=0, out_imm=0. Other fields are still latched.
- Operand resolution, per source:
  - address 0 yields 0;
  - otherwise EX match (ex_we, ex_waddr, not ex_is_load) wins;
  - then MEM match;
  - then rdata. Forwarding applies only when FWD_EN=1.
- Hazard (stall) asserts when in_valid and a used source (re=1, addr≠0) matches any of:
  - the output register holding a valid load with out_we;
  - EX with ex_is_load && ex_we;
  - with FWD_EN=0, any EX/MEM write.
- in_ready = flush | (!stall & (!out_valid | out_ready)).
- Capture: in_valid & in_ready & !flush loads the output register and sets out_valid=1.
- Drain: out_valid & out_ready without a new capture clears out_valid.
- Back-to-back transfers are allowed: capture and drain in the same cycle.
- Flush clears out_valid next cycle. The beat offered that cycle is consumed and discarded. Flush has priority over capture and stall.
- stall_cnt increments each cycle in which in_valid & stall & !flush, saturating at 2^CNT_W−1.

## Timing
- Decode latency: 1 cycle, in accept → out_valid.
- Throughput: 1 instruction/cycle absent hazards.
- Output fields change only on capture. While out_valid & !out_ready they hold stable.
- Load-use costs exactly 1 bubble when the load drains the next cycle. The dependent instruction then accepts with MEM forwarding of the loaded data.
- Reset: out_valid=0, all out_* fields 0, stall_cnt=0. in_ready=1 in the first cycle after reset.
- rst during a pending transfer discards it. rst overrides flush.
- re/raddr, in_ready and stall are combinational and registered nowhere.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) offered with out_ready=1 → next cycle out_valid=1, opcode 0x13, funct3 0, imm 5, we=1, waddr 1, op1 0.
- ex_we=1, ex_waddr=2, ex_wdata=0xDEAD; mem_we=1, mem_waddr=2, mem_wdata=0x1111; add x3,x2,x2 → op1=op2=0xDEAD. Repeat with FWD_EN=0 → in_ready=0 while hazard held, stall_cnt counts.
- lw x5,0(x1) then add x6,x5,x5 back-to-back → in_ready=0 for 1 cycle, stall_cnt=1. add accepted next cycle with op1=op2=mem_wdata.
- out_ready=0 for 3 cycles with out_valid=1 → outputs stable, in_ready=0. out_ready=1 → new instruction captured the same cycle.
- flush with out_valid=1 and in_valid=1 → in_ready=1, out_valid=0 next cycle, flushed beat never appears.
- 0xFFFFFFFF → out_illegal=1, out_we=0. With CNT_W=2 and a held hazard of 5 cycles, stall_cnt reaches 3 and stays 3.
